// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants, init-entry layout and state encoding for the LCD command sequencer
package lcd_pkg;

  localparam logic [15:0] CMD_COLSET = 16'h002A;
  localparam logic [15:0] CMD_ROWSET = 16'h002B;
  localparam logic [15:0] CMD_MEMWR  = 16'h002C;
  localparam logic [15:0] CMD_NOP    = 16'h0000;

  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

  // Init entry: {is_delay, rs, data16}
  localparam int ENT_W        = 18;
  localparam int ENT_DELAY    = 17;
  localparam int ENT_RS       = 16;
  localparam int ENT_DATA_MSB = 15;
  localparam int ENT_DATA_LSB = 0;

  localparam int IDX_W   = 8;
  localparam int HDR_LEN = 11;

  typedef logic [ENT_W-1:0] init_entry_t;

  typedef enum logic [2:0] {
    ST_RST_WAIT,
    ST_INIT_FETCH,
    ST_INIT_DELAY,
    ST_IDLE,
    ST_CMD,
    ST_PIXELS,
    ST_DONE
  } seq_state_e;

  function automatic init_entry_t init_cmd(input logic [15:0] c);
    return {1'b0, RS_CMD, c};
  endfunction

  function automatic init_entry_t init_dat(input logic [15:0] d);
    return {1'b0, RS_DATA, d};
  endfunction

  function automatic init_entry_t init_dly(input logic [15:0] units);
    return {1'b1, RS_CMD, units};
  endfunction

  // Window header: column set, four x bytes, row set, four y bytes, memory write
  function automatic logic [16:0] hdr_word(input logic [3:0] idx,
                                           input logic [15:0] x0, input logic [15:0] x1,
                                           input logic [15:0] y0, input logic [15:0] y1);
    logic [16:0] w;
    case (idx)
      4'd0:    w = {RS_CMD, CMD_COLSET};
      4'd1:    w = {RS_DATA, 8'h00, x0[15:8]};
      4'd2:    w = {RS_DATA, 8'h00, x0[7:0]};
      4'd3:    w = {RS_DATA, 8'h00, x1[15:8]};
      4'd4:    w = {RS_DATA, 8'h00, x1[7:0]};
      4'd5:    w = {RS_CMD, CMD_ROWSET};
      4'd6:    w = {RS_DATA, 8'h00, y0[15:8]};
      4'd7:    w = {RS_DATA, 8'h00, y0[7:0]};
      4'd8:    w = {RS_DATA, 8'h00, y1[15:8]};
      4'd9:    w = {RS_DATA, 8'h00, y1[7:0]};
      default: w = {RS_CMD, CMD_MEMWR};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// rtl/lcd_init_rom.sv - combinational panel init table; VARIANT 1 is a short table for simulation
module lcd_init_rom
  import lcd_pkg::*;
#(
  parameter int INIT_LEN = 8,
  parameter int VARIANT  = 0
) (
  input  logic [IDX_W-1:0] i_idx,
  output init_entry_t      o_entry
);

  always_comb begin
    o_entry = init_cmd(CMD_NOP);
    if (VARIANT == 1) begin
      case (i_idx)
        8'd0:    o_entry = init_cmd(16'h0011);
        8'd1:    o_entry = init_dly(16'd2);
        8'd2:    o_entry = init_dat(16'h0055);
        default: o_entry = init_cmd(CMD_NOP);
      endcase
    end else begin
      case (i_idx)
        8'd0:    o_entry = init_cmd(16'h0001);
        8'd1:    o_entry = init_dly(16'd5);
        8'd2:    o_entry = init_cmd(16'h0011);
        8'd3:    o_entry = init_dly(16'd120);
        8'd4:    o_entry = init_cmd(16'h003A);
        8'd5:    o_entry = init_dat(16'h0055);
        8'd6:    o_entry = init_cmd(16'h0029);
        8'd7:    o_entry = init_dly(16'd10);
        default: o_entry = init_cmd(CMD_NOP);
      endcase
    end
    // Indices past the table length read as a harmless NOP
    if (int'(i_idx) >= INIT_LEN) o_entry = init_cmd(CMD_NOP);
  end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// rtl/lcd_cmd_sequencer.sv - power-up wait, ROM init, then rectangle fills fed word by word to the LCD poster
module lcd_cmd_sequencer
  import lcd_pkg::*;
#(
  parameter int POWER_DELAY = 50000,
  parameter int DELAY_UNIT  = 1000,
  parameter int INIT_LEN    = 8,
  parameter int COORD_W     = 16,
  parameter int ROM_VARIANT = 0
) (
  input  logic               clk,
  input  logic               resetn,
  output logic [16:0]        post_data,
  output logic               post_flag,
  input  logic               post_busy,
  input  logic               fill_valid,
  output logic               fill_ready,
  input  logic [COORD_W-1:0] fill_x0,
  input  logic [COORD_W-1:0] fill_x1,
  input  logic [COORD_W-1:0] fill_y0,
  input  logic [COORD_W-1:0] fill_y1,
  input  logic [15:0]        fill_color,
  output logic               init_done,
  output logic               fill_done,
  output logic               seq_busy
);

  seq_state_e         r_state, w_state_nxt;
  logic [31:0]        r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [3:0]         r_hdr;
  logic [COORD_W-1:0] r_x0, r_x1, r_y0, r_y1, r_col, r_row;
  logic [15:0]        r_color;
  logic [16:0]        r_post_data;
  logic               r_post_flag;
  logic               r_hold;
  logic               r_init_done;

  init_entry_t        w_entry;
  logic [31:0]        w_dly_cycles;
  logic               w_can_issue, w_issue, w_idx_adv, w_last_entry, w_degen, w_last_pix;
  logic [16:0]        w_word;

  lcd_init_rom #(
    .INIT_LEN (INIT_LEN),
    .VARIANT  (ROM_VARIANT)
  ) u_rom (
    .i_idx   (r_idx),
    .o_entry (w_entry)
  );

  // r_hold keeps issues at least two cycles apart even if busy is slow to rise
  assign w_can_issue  = !post_busy && !r_hold;
  assign w_dly_cycles = 32'(w_entry[ENT_DATA_MSB:ENT_DATA_LSB]) * 32'(DELAY_UNIT);
  assign w_last_entry = (r_idx == IDX_W'(INIT_LEN - 1));
  assign w_degen      = (fill_x1 < fill_x0) || (fill_y1 < fill_y0);
  assign w_last_pix   = (r_col == r_x1) && (r_row == r_y1);

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_word      = '0;
    w_idx_adv   = 1'b0;
    case (r_state)
      ST_RST_WAIT: begin
        if ((r_cnt + 32'd1) >= 32'(POWER_DELAY)) w_state_nxt = ST_INIT_FETCH;
      end
      ST_INIT_FETCH: begin
        if (w_entry[ENT_DELAY]) begin
          if (w_dly_cycles == 32'd0) w_idx_adv = 1'b1;
          else                       w_state_nxt = ST_INIT_DELAY;
        end else if (w_can_issue) begin
          w_issue   = 1'b1;
          w_word    = w_entry[ENT_RS:ENT_DATA_LSB];
          w_idx_adv = 1'b1;
        end
      end
      ST_INIT_DELAY: begin
        if (r_cnt <= 32'd1) w_idx_adv = 1'b1;
      end
      ST_IDLE: begin
        if (fill_valid) w_state_nxt = w_degen ? ST_DONE : ST_CMD;
      end
      ST_CMD: begin
        if (w_can_issue) begin
          w_issue = 1'b1;
          w_word  = hdr_word(r_hdr, 16'(r_x0), 16'(r_x1), 16'(r_y0), 16'(r_y1));
          if (r_hdr == 4'(HDR_LEN - 1)) w_state_nxt = ST_PIXELS;
        end
      end
      ST_PIXELS: begin
        if (w_can_issue) begin
          w_issue = 1'b1;
          w_word  = {RS_DATA, r_color};
          if (w_last_pix) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_RST_WAIT;
    endcase
    if (w_idx_adv) w_state_nxt = w_last_entry ? ST_IDLE : ST_INIT_FETCH;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_RST_WAIT;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_hdr       <= '0;
      r_x0        <= '0;
      r_x1        <= '0;
      r_y0        <= '0;
      r_y1        <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_color     <= '0;
      r_post_data <= '0;
      r_post_flag <= 1'b0;
      r_hold      <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_issue;
      if (w_issue) begin
        r_post_data <= w_word;
        r_post_flag <= ~r_post_flag;
      end
      case (r_state)
        ST_RST_WAIT:   r_cnt <= (w_state_nxt == ST_RST_WAIT) ? r_cnt + 32'd1 : 32'd0;
        ST_INIT_FETCH: if (w_state_nxt == ST_INIT_DELAY) r_cnt <= w_dly_cycles;
        ST_INIT_DELAY: r_cnt <= r_cnt - 32'd1;
        ST_IDLE: begin
          r_hdr <= '0;
          if (fill_valid) begin
            r_x0    <= fill_x0;
            r_x1    <= fill_x1;
            r_y0    <= fill_y0;
            r_y1    <= fill_y1;
            r_color <= fill_color;
          end
        end
        ST_CMD: begin
          if (w_issue) r_hdr <= r_hdr + 4'd1;
          r_col <= r_x0;
          r_row <= r_y0;
        end
        ST_PIXELS: begin
          // Equality tested before incrementing so 0xFFFF corners never wrap
          if (w_issue && !w_last_pix) begin
            if (r_col == r_x1) begin
              r_col <= r_x0;
              r_row <= r_row + COORD_W'(1);
            end else begin
              r_col <= r_col + COORD_W'(1);
            end
          end
        end
        default: ;
      endcase
      if (w_idx_adv) begin
        r_idx <= r_idx + IDX_W'(1);
        if (w_last_entry) r_init_done <= 1'b1;
      end
    end
  end

  assign post_data  = r_post_data;
  assign post_flag  = r_post_flag;
  assign init_done  = r_init_done;
  assign fill_ready = (r_state == ST_IDLE);
  assign fill_done  = (r_state == ST_DONE);
  assign seq_busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb/tb_lcd_cmd_sequencer.sv - scoreboard bench with a poster model for lcd_cmd_sequencer
module tb_lcd_cmd_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic [16:0] post_data;
  logic        post_flag;
  logic        post_busy = 1'b0;
  logic        fill_valid;
  logic        fill_ready;
  logic [15:0] fill_x0, fill_x1, fill_y0, fill_y1, fill_color;
  logic        init_done, fill_done, seq_busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [16:0] exp_q[$];
  int tog_cycles[$];
  int tog_total = 0;
  int done_pulses = 0;
  int busy_len = 7;
  int busy_cnt = 0;
  int cyc = 0;
  int init_rise_cyc = -1;
  logic prev_flag, prev_issue, prev_done, prev_init;
  logic [16:0] prev_data;

  lcd_cmd_sequencer #(
    .POWER_DELAY (20),
    .DELAY_UNIT  (5),
    .INIT_LEN    (3),
    .COORD_W     (16),
    .ROM_VARIANT (1)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .post_data  (post_data),
    .post_flag  (post_flag),
    .post_busy  (post_busy),
    .fill_valid (fill_valid),
    .fill_ready (fill_ready),
    .fill_x0    (fill_x0),
    .fill_x1    (fill_x1),
    .fill_y0    (fill_y0),
    .fill_y1    (fill_y1),
    .fill_color (fill_color),
    .init_done  (init_done),
    .fill_done  (fill_done),
    .seq_busy   (seq_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Poster model and output monitor; busy rises the cycle after each toggle
  always @(negedge clk) begin
    if (!resetn) begin
      prev_flag  = post_flag;
      prev_data  = post_data;
      prev_issue = 1'b0;
      prev_done  = 1'b0;
      prev_init  = 1'b0;
      busy_cnt   = 0;
      post_busy  = 1'b0;
    end else begin
      if (post_flag != prev_flag) begin
        chk("issue_while_busy", {31'd0, post_busy}, 32'd0);
        chk("back_to_back_issue", {31'd0, prev_issue}, 32'd0);
        tog_total++;
        tog_cycles.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {15'd0, post_data}, 32'h1ffff);
        end else begin
          chk("word", {15'd0, post_data}, {15'd0, exp_q.pop_front()});
        end
        busy_cnt   = busy_len;
        prev_issue = 1'b1;
      end else begin
        if (post_busy) chk("data_stable_in_busy", {15'd0, post_data}, {15'd0, prev_data});
        if (busy_cnt > 0) busy_cnt--;
        prev_issue = 1'b0;
      end
      post_busy = (busy_cnt != 0);
      prev_flag = post_flag;
      prev_data = post_data;
      if (fill_done) begin
        if (prev_done) chk("fill_done_width", 32'd2, 32'd1);
        done_pulses++;
      end
      prev_done = fill_done;
      if (init_done && !prev_init) init_rise_cyc = cyc;
      prev_init = init_done;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Reference: header bytes from the corners, then width*height copies of the colour
  function automatic int model_fill(input logic [15:0] x0, input logic [15:0] x1,
                                    input logic [15:0] y0, input logic [15:0] y1,
                                    input logic [15:0] c);
    int npix;
    if (x1 < x0 || y1 < y0) return 0;
    exp_q.push_back({1'b0, 16'h002A});
    exp_q.push_back({1'b1, 8'h00, x0[15:8]});
    exp_q.push_back({1'b1, 8'h00, x0[7:0]});
    exp_q.push_back({1'b1, 8'h00, x1[15:8]});
    exp_q.push_back({1'b1, 8'h00, x1[7:0]});
    exp_q.push_back({1'b0, 16'h002B});
    exp_q.push_back({1'b1, 8'h00, y0[15:8]});
    exp_q.push_back({1'b1, 8'h00, y0[7:0]});
    exp_q.push_back({1'b1, 8'h00, y1[15:8]});
    exp_q.push_back({1'b1, 8'h00, y1[7:0]});
    exp_q.push_back({1'b0, 16'h002C});
    npix = (int'(x1) - int'(x0) + 1) * (int'(y1) - int'(y0) + 1);
    for (int i = 0; i < npix; i++) exp_q.push_back({1'b1, c});
    return 11 + npix;
  endfunction

  task automatic start_fill(input logic [15:0] x0, input logic [15:0] x1,
                            input logic [15:0] y0, input logic [15:0] y1,
                            input logic [15:0] c, input int hold, output int n_exp);
    n_exp = model_fill(x0, x1, y0, y1, c);
    fill_x0 = x0; fill_x1 = x1; fill_y0 = y0; fill_y1 = y1; fill_color = c;
    fill_valid = 1'b1;
    step();
    if (n_exp == 0) chk("degen_done_next_cycle", {31'd0, fill_done}, 32'd1);
    if (hold > 0) begin
      fill_x0 = 16'd0; fill_x1 = 16'd9; fill_y0 = 16'd0; fill_y1 = 16'd9; fill_color = ~c;
      repeat (hold) step();
    end
    fill_valid = 1'b0;
  endtask

  task automatic do_fill(input logic [15:0] x0, input logic [15:0] x1,
                         input logic [15:0] y0, input logic [15:0] y1,
                         input logic [15:0] c, input int hold);
    int t0, d0, n_exp, budget;
    for (int i = 0; i < 3000 && !fill_ready; i++) step();
    chk("fill_ready_before", {31'd0, fill_ready}, 32'd1);
    t0 = tog_total;
    d0 = done_pulses;
    start_fill(x0, x1, y0, y1, c, hold, n_exp);
    budget = (n_exp + 2) * (busy_len + 4) + 20;
    for (int i = 0; i < budget && done_pulses == d0; i++) step();
    chk("fill_done_count", done_pulses - d0, 32'd1);
    chk("fill_ready_at_done", {31'd0, fill_ready}, 32'd0);
    step();
    chk("fill_ready_after_done", {31'd0, fill_ready}, 32'd1);
    chk("fill_done_dropped", {31'd0, fill_done}, 32'd0);
    chk("word_count", tog_total - t0, n_exp);
    chk("queue_drained", exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_values();
    chk("rst_post_data", {15'd0, post_data}, 32'd0);
    chk("rst_post_flag", {31'd0, post_flag}, 32'd0);
    chk("rst_fill_ready", {31'd0, fill_ready}, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_fill_done", {31'd0, fill_done}, 32'd0);
    chk("rst_seq_busy", {31'd0, seq_busy}, 32'd1);
  endtask

  task automatic run_init_and_check();
    tog_cycles.delete();
    init_rise_cyc = -1;
    exp_q.push_back(17'h00011);
    exp_q.push_back(17'h10055);
    resetn = 1'b1;
    for (int i = 0; i < 300 && !init_done; i++) step();
    chk("init_done_set", {31'd0, init_done}, 32'd1);
    chk("init_word_count", tog_cycles.size(), 32'd2);
    if (tog_cycles.size() == 2) begin
      chk("first_toggle_cycle", tog_cycles[0], 32'd21);
      chk("init_delay_gap", {31'd0, (tog_cycles[1] - tog_cycles[0]) >= 11}, 32'd1);
      chk("init_done_after_last", {31'd0, init_rise_cyc >= tog_cycles[1]}, 32'd1);
    end
    step();
    chk("idle_ready", {31'd0, fill_ready}, 32'd1);
    chk("idle_not_busy", {31'd0, seq_busy}, 32'd0);
  endtask

  initial begin
    int t0, n;
    logic [15:0] x0, x1, y0, y1;
    resetn = 1'b0;
    fill_valid = 1'b0;
    fill_x0 = '0; fill_x1 = '0; fill_y0 = '0; fill_y1 = '0; fill_color = '0;
    repeat (3) step();
    check_reset_values();
    run_init_and_check();

    do_fill(16'd1, 16'd2, 16'd3, 16'd3, 16'hF800, 0);

    busy_len = 30;
    do_fill(16'd2, 16'd3, 16'd7, 16'd7, 16'h07E0, 0);
    busy_len = 7;

    do_fill(16'd5, 16'd4, 16'd0, 16'd0, 16'h001F, 0);
    do_fill(16'd0, 16'd0, 16'd9, 16'd8, 16'h001F, 0);

    do_fill(16'd0, 16'd3, 16'd0, 16'd1, 16'h1234, 40);

    do_fill(16'd7, 16'd7, 16'd300, 16'd300, 16'hABCD, 0);
    do_fill(16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h5A5A, 0);

    for (int k = 0; k < 8; k++) begin
      x0 = 16'($urandom_range(1, 600));
      y0 = 16'($urandom_range(1, 600));
      x1 = x0 + 16'($urandom_range(0, 3));
      y1 = y0 + 16'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) x1 = x0 - 16'd1;
      if ($urandom_range(0, 5) == 0) y1 = y0 - 16'd1;
      busy_len = $urandom_range(7, 12);
      do_fill(x0, x1, y0, y1, 16'($urandom), 0);
    end
    busy_len = 7;

    t0 = tog_total;
    start_fill(16'd0, 16'd15, 16'd0, 16'd15, 16'hC0DE, 0, n);
    for (int i = 0; i < 2000 && (tog_total - t0) < 20; i++) step();
    chk("midstream_reached", {31'd0, (tog_total - t0) >= 20}, 32'd1);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check_reset_values();
    exp_q.delete();
    step();
    step();
    run_init_and_check();
    do_fill(16'd3, 16'd4, 16'd5, 16'd5, 16'h0F0F, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #700000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
